// File: rtl/data_mem_port.sv
// data_mem_port: CPU-side responder between the MEM stage and the 2048x32
// data BRAM. Maps MIPS virtual addresses onto BRAM word indices and performs
// byte, halfword and word loads and stores. Sub-word stores use a
// read-modify-write because the BRAM only writes full words. Bad or
// misaligned addresses answer with resp_err and are latched for the
// exception unit.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and out of reset.
// resp_valid is a one-cycle pulse with no back-pressure. resp_err and
// resp_rdata are meaningful only while resp_valid is high.
module data_mem_port #(
    parameter logic [31:0] GLOBAL_BASE = 32'h10010000,
    parameter logic [31:0] STACK_BASE  = 32'h7FFFEFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] bad_vaddr,
    output logic [1:0]  exc_cause,
    input  logic        exc_clear
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [10:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] bad_vaddr_q, bad_vaddr_d;
    logic [1:0]  exc_cause_q, exc_cause_d;

    logic [31:0] g_off, s_off;
    logic        in_global, in_stack, misaligned, req_err;
    logic [10:0] req_idx;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v, merged_v;
    logic        mem_active;

    // Decode the incoming virtual address into a word index and a fault flag.
    always_comb begin
        g_off     = req_addr - GLOBAL_BASE;
        s_off     = req_addr - STACK_BASE;
        in_global = (g_off < 32'h0000_1000);
        in_stack  = (s_off < 32'h0000_1000);
        req_idx   = in_global ? {1'b0, g_off[11:2]} : {1'b1, s_off[11:2]};
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        req_err = !(in_global || in_stack) || misaligned;
    end

    // Lane extraction for loads and lane merge for sub-word stores (little-endian).
    always_comb begin
        byte_v   = mem_rdata[{lane_q, 3'b000} +: 8];
        half_v   = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        merged_v = mem_rdata;
        if (size_q == 2'b00) begin
            merged_v[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_v[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
        case (size_q)
            2'b00:   load_v = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'b01:   load_v = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_v = mem_rdata;
        endcase
    end

    // Next-state logic for the access sequencer and the exception latch.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        write_d     = write_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bad_vaddr_d = bad_vaddr_q;
        exc_cause_d = exc_cause_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    err_d   = req_err;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_RDW;
            S_RDW: begin
                if (write_q) begin
                    wdata_d = merged_v;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_v;
                    state_d = S_RESP;
                end
            end
            S_WR:   state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // First fault wins; a fault arriving with exc_clear replaces the old one.
        if ((state_q == S_IDLE) && req_valid && req_err &&
            ((exc_cause_q == 2'b00) || exc_clear)) begin
            exc_cause_d = req_write ? 2'b10 : 2'b01;
            bad_vaddr_d = req_addr;
        end else if (exc_clear) begin
            exc_cause_d = 2'b00;
            bad_vaddr_d = 32'h0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= 11'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            bad_vaddr_q <= 32'h0;
            exc_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bad_vaddr_q <= bad_vaddr_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    // Outputs decode from state; strobes are forced low while reset is held.
    always_comb begin
        mem_active = (state_q == S_RD) || (state_q == S_WR);
        req_ready  = rst && (state_q == S_IDLE);
        resp_valid = rst && (state_q == S_RESP);
        resp_err   = rst && (state_q == S_RESP) && err_q;
        resp_rdata = rdata_q;
        mem_en     = rst && mem_active;
        mem_we     = rst && (state_q == S_WR);
        mem_addr   = mem_active ? idx_q : 11'h0;
        mem_wdata  = (state_q == S_WR) ? wdata_q : 32'h0;
        bad_vaddr  = bad_vaddr_q;
        exc_cause  = exc_cause_q;
    end

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed bench for data_mem_port with a transaction-level
// reference model, a BRAM model and a per-cycle compare process.
module tb_data_mem_port;

    localparam logic [31:0] GBASE = 32'h10010000;
    localparam logic [31:0] SBASE = 32'h7FFFEFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned, exc_clear;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
    logic [31:0] resp_rdata, mem_wdata, bad_vaddr;
    logic [31:0] mem_rdata;
    logic [10:0] mem_addr;
    logic [1:0]  exc_cause;
    logic        init_all;

    int checks = 0;
    int failures = 0;

    // Values captured by the compare process for the directed literal checks.
    int          resp_cnt = 0;
    int          last_lat = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_err = 32'h0;
    logic [31:0] last_we_addr = 32'h0;
    logic [31:0] last_we_data = 32'h0;
    logic [31:0] resp_log[$];

    // Reference memory image and transaction model state.
    logic [31:0] ref_mem [0:2047];
    logic [31:0] bram [0:2047];

    always #5 clk = ~clk;

    data_mem_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bad_vaddr(bad_vaddr),
        .exc_cause(exc_cause), .exc_clear(exc_clear)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 2) return 32'h11223344;
        return 32'hA5A50000 | 32'(i);
    endfunction

    // Single-port BRAM: registered read, full-word write.
    always @(posedge clk) begin
        if (init_all) begin
            for (int i = 0; i < 2048; i++) bram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model plus per-cycle comparison, sampled 1 time unit after each edge.
    initial begin : compare
        logic        m_active, m_write, m_err, m_uns, ok, mis, acc, rd, wr, rsp;
        logic [1:0]  m_size, m_cause;
        logic [31:0] m_bad, m_idx, m_wval, m_rval, off_g, off_s, w, v;
        int          m_t, m_lat, sh, cyc, acc_cyc;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
        m_active = 1'b0; m_write = 1'b0; m_err = 1'b0; m_uns = 1'b0;
        m_size = 2'b00; m_cause = 2'b00; m_bad = 32'h0; m_idx = 32'h0;
        m_wval = 32'h0; m_rval = 32'h0; m_t = 0; m_lat = 0; cyc = 0; acc_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            acc = 1'b0;
            if (!rst) begin
                m_active = 1'b0;
                m_cause  = 2'b00;
                m_bad    = 32'h0;
            end else begin
                if (m_active && m_write && !m_err && (m_t == m_lat - 1)) ref_mem[m_idx[10:0]] = m_wval;
                acc = req_valid && !m_active;
                if (acc) begin
                    m_write = req_write; m_size = req_size; m_uns = req_unsigned;
                    off_g = req_addr - GBASE;
                    off_s = req_addr - SBASE;
                    ok = 1'b1; m_idx = 32'h0;
                    if (off_g < 32'd4096)      m_idx = off_g >> 2;
                    else if (off_s < 32'd4096) m_idx = 32'd1024 + (off_s >> 2);
                    else                       ok = 1'b0;
                    mis = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'd0);
                    m_err = !ok || mis;
                    sh = int'(req_addr[1:0]) * 8;
                    w = ref_mem[m_idx[10:0]];
                    m_rval = 32'h0; m_wval = 32'h0;
                    if (m_err)                          m_lat = 1;
                    else if (req_write && req_size == 2) m_lat = 2;
                    else if (req_write)                 m_lat = 4;
                    else                                m_lat = 3;
                    if (!m_err && req_write) begin
                        if (req_size == 2'd0)      m_wval = (w & ~(32'hFF << sh)) | ((req_wdata & 32'hFF) << sh);
                        else if (req_size == 2'd1) m_wval = (w & ~(32'hFFFF << sh)) | ((req_wdata & 32'hFFFF) << sh);
                        else                       m_wval = req_wdata;
                    end else if (!m_err) begin
                        v = w >> sh;
                        if (req_size == 2'd0) begin
                            v = v & 32'hFF;
                            if (!req_unsigned && v >= 32'd128) v = v | 32'hFFFFFF00;
                        end else if (req_size == 2'd1) begin
                            v = v & 32'hFFFF;
                            if (!req_unsigned && v >= 32'd32768) v = v | 32'hFFFF0000;
                        end
                        m_rval = v;
                    end
                    m_active = 1'b1;
                    m_t = 0;
                    acc_cyc = cyc;
                end
                if (acc && m_err && (m_cause == 2'b00 || exc_clear)) begin
                    m_cause = req_write ? 2'b10 : 2'b01;
                    m_bad   = req_addr;
                end else if (exc_clear) begin
                    m_cause = 2'b00;
                    m_bad   = 32'h0;
                end
                if (m_active) begin
                    m_t++;
                    if (m_t > m_lat) m_active = 1'b0;
                end
            end
            rd  = m_active && !m_err && (m_t == 1) && !(m_write && m_size == 2'd2);
            wr  = m_active && !m_err && m_write && (m_t == m_lat - 1);
            rsp = m_active && (m_t == m_lat);
            chk("req_ready",  32'(req_ready),  32'(rst && !m_active));
            chk("resp_valid", 32'(resp_valid), 32'(rsp));
            chk("mem_en",     32'(mem_en),     32'(rd || wr));
            chk("mem_we",     32'(mem_we),     32'(wr));
            chk("mem_addr",   32'(mem_addr),   (rd || wr) ? m_idx : 32'h0);
            chk("mem_wdata",  mem_wdata,       wr ? m_wval : 32'h0);
            chk("exc_cause",  32'(exc_cause),  32'(m_cause));
            chk("bad_vaddr",  bad_vaddr,       m_bad);
            if (rsp) begin
                chk("resp_err",   32'(resp_err), 32'(m_err));
                chk("resp_rdata", resp_rdata,    m_rval);
            end
            if (mem_we === 1'b1) begin
                last_we_addr = 32'(mem_addr);
                last_we_data = mem_wdata;
            end
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                last_rdata = resp_rdata;
                last_err   = 32'(resp_err);
                last_lat   = cyc - acc_cyc + 1;
                resp_log.push_back(resp_rdata);
            end
        end
    end

    // Present a request and wait (bounded) for it to be accepted.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic clr, input logic keep);
        int n;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d; req_valid = 1'b1; exc_clear = clr;
        n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 30), 32'h1);
        @(negedge clk);
        exc_clear = 1'b0;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int cnt0, input int k);
        int n;
        n = 0;
        while (resp_cnt < cnt0 + k && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("resp_in_time", 32'(resp_cnt >= cnt0 + k), 32'h1);
    endtask

    task automatic xact(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic clr);
        int cnt0;
        cnt0 = resp_cnt;
        do_req(w, sz, uns, a, d, clr, 1'b0);
        wait_resp(cnt0, 1);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin : stim
        int cnt0, n0, diffs;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        exc_clear = 1'b0; init_all = 1'b1;
        repeat (3) @(negedge clk);
        init_all = 1'b0;
        chk("rst_ready",      32'(req_ready),  32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_mem_en",     32'(mem_en),     32'h0);
        chk("rst_rdata",      resp_rdata,      32'h0);
        chk("rst_cause",      32'(exc_cause),  32'h0);
        chk("rst_bad",        bad_vaddr,       32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'h1);

        // word store then load
        xact(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, 1'b0);
        chk("sw_lat", 32'(last_lat), 32'd2);
        chk("sw_we_addr", last_we_addr, 32'h001);
        chk("sw_we_data", last_we_data, 32'hDEADBEEF);
        xact(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, 1'b0);
        chk("lw_lat", 32'(last_lat), 32'd3);
        chk("lw_data", last_rdata, 32'hDEADBEEF);
        chk("lw_err", last_err, 32'h0);

        // stack mapping
        xact(1'b1, 2'b10, 1'b0, 32'h7FFFEFFC, 32'h0BADF00D, 1'b0);
        chk("stack_lo_addr", last_we_addr, 32'h400);
        xact(1'b1, 2'b10, 1'b0, 32'h7FFFFFF8, 32'hCAFE0001, 1'b0);
        chk("stack_hi_addr", last_we_addr, 32'h7FF);

        // sub-word store and extending loads on 0x11223344
        xact(1'b1, 2'b00, 1'b0, 32'h1001000A, 32'h000000AB, 1'b0);
        chk("sb_lat", 32'(last_lat), 32'd4);
        chk("sb_merge", last_we_data, 32'h11AB3344);
        xact(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, 1'b0);
        chk("sb_word", last_rdata, 32'h11AB3344);
        xact(1'b0, 2'b00, 1'b0, 32'h1001000A, 32'h0, 1'b0);
        chk("lb_sext", last_rdata, 32'hFFFFFFAB);
        xact(1'b0, 2'b00, 1'b1, 32'h1001000A, 32'h0, 1'b0);
        chk("lbu_zext", last_rdata, 32'h000000AB);
        xact(1'b0, 2'b01, 1'b0, 32'h1001000A, 32'h0, 1'b0);
        chk("lh_hi", last_rdata, 32'h000011AB);
        xact(1'b1, 2'b01, 1'b0, 32'h10010008, 32'h12348001, 1'b0);
        chk("sh_merge", last_we_data, 32'h11AB8001);
        xact(1'b0, 2'b01, 1'b0, 32'h10010008, 32'h0, 1'b0);
        chk("lh_sext", last_rdata, 32'hFFFF8001);
        xact(1'b0, 2'b01, 1'b1, 32'h10010008, 32'h0, 1'b0);
        chk("lhu_zext", last_rdata, 32'h00008001);

        // faults and the exception latch
        xact(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, 1'b0);
        chk("adel_lat", 32'(last_lat), 32'd1);
        chk("adel_err", last_err, 32'h1);
        chk("adel_cause", 32'(exc_cause), 32'h1);
        chk("adel_bad", bad_vaddr, 32'h10010002);
        xact(1'b1, 2'b10, 1'b0, 32'h7FFFFFFC, 32'h1, 1'b0);
        chk("sticky_err", last_err, 32'h1);
        chk("sticky_cause", 32'(exc_cause), 32'h1);
        chk("sticky_bad", bad_vaddr, 32'h10010002);
        xact(1'b1, 2'b01, 1'b0, 32'h00000000, 32'h1, 1'b1);
        chk("clr_fault_cause", 32'(exc_cause), 32'h2);
        chk("clr_fault_bad", bad_vaddr, 32'h0);
        @(negedge clk); exc_clear = 1'b1;
        @(negedge clk); exc_clear = 1'b0;
        chk("clear_cause", 32'(exc_cause), 32'h0);
        xact(1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0, 1'b0);
        chk("size3_err", last_err, 32'h1);
        chk("size3_bad", bad_vaddr, 32'h10010000);

        // reset during the RDW cycle of a byte store
        cnt0 = resp_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h10010010, 32'h0000005A, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'h1);
        repeat (4) @(negedge clk);
        chk("abort_no_resp", 32'(resp_cnt), 32'(cnt0));
        xact(1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, 1'b0);
        chk("abort_word", last_rdata, 32'hA5A50004);

        // back-to-back with req_valid held
        cnt0 = resp_cnt;
        n0 = resp_log.size();
        do_req(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 2'b00, 1'b1, 32'h1001000B, 32'h0, 1'b0, 1'b0);
        wait_resp(cnt0, 2);
        chk("b2b_count", 32'(resp_log.size() - n0), 32'd2);
        if (resp_log.size() >= n0 + 2) begin
            chk("b2b_first", resp_log[n0], 32'hDEADBEEF);
            chk("b2b_second", resp_log[n0 + 1], 32'h00000011);
        end

        // final memory image against the reference
        repeat (3) @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 2048; i++) if (bram[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
